// File: rtl/mdu_if.sv
// mdu_if: EX-stage request and result bundle for the multiply/divide unit.
// The EX stage side (master) drives start/op/a/b. The MDU side (slave)
// returns busy, xstall, the HI/LO registers and a one-bit FSM state for
// observation.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        xstall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;  // 0 = IDLE, 1 = RUN

  modport master (output start, op, a, b,
                  input  busy, xstall, hi, lo, dbg_state);
  modport slave  (input  start, op, a, b,
                  output busy, xstall, hi, lo, dbg_state);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// Handshake: there is no ready signal. An op is taken on any rising edge
// where start=1 and the unit is IDLE. While busy=1 every start is dropped.
// xstall tells the hazard unit to hold HI/LO readers and any new MDU op.
//
// The result is computed in the accepting cycle and held in a register.
// A countdown then models the latency, and the held result is written to
// HI/LO on the last busy edge.
//
// Optional build macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (ops 6-9). When it is not defined, those ops are reserved.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [31:0] MULT_LOAD = 32'(MULT_CYCLES);
  localparam logic [31:0] DIV_LOAD  = 32'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [63:0] res_q, res_d;
  logic        commit_q, commit_d;  // low for divide-by-zero: keep HI/LO
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Op decode.
  logic is_mul, is_div, is_signed, is_mac, is_sub, is_multi;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quot, rem;

  // Operand decode and the arithmetic for the op on the bus.
  always_comb begin
    is_mul    = (bus.op == 4'd0) || (bus.op == 4'd1);
    is_div    = (bus.op == 4'd2) || (bus.op == 4'd3);
`ifdef MDU_MADD_EN
    is_mac    = (bus.op >= 4'd6) && (bus.op <= 4'd9);
    is_sub    = (bus.op == 4'd8) || (bus.op == 4'd9);
    is_signed = (bus.op == 4'd0) || (bus.op == 4'd2) ||
                (bus.op == 4'd6) || (bus.op == 4'd8);
`else
    is_mac    = 1'b0;
    is_sub    = 1'b0;
    is_signed = (bus.op == 4'd0) || (bus.op == 4'd2);
`endif
    is_multi  = is_mul || is_div || is_mac;

    // The low 64 bits of the product of the sign- or zero-extended operands
    // are the correct signed or unsigned 64-bit product.
    if (is_signed)
      prod = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    else
      prod = {32'd0, bus.a} * {32'd0, bus.b};

    // Signed divide works on magnitudes, and the signs are fixed up at the
    // end. With this scheme 0x80000000 / -1 wraps to 0x80000000 without
    // overflow.
    a_mag  = (is_signed && bus.a[31]) ? -bus.a : bus.a;
    b_mag  = (is_signed && bus.b[31]) ? -bus.b : bus.b;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    quot   = (is_signed && (bus.a[31] ^ bus.b[31])) ? -uq : uq;
    rem    = (is_signed && bus.a[31]) ? -ur : ur;
  end

  // State register and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 32'd0;
      res_q    <= 64'd0;
      commit_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      res_q    <= res_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next state: accept in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    res_d    = res_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == 4'd4) hi_d = bus.a;
          if (bus.op == 4'd5) lo_d = bus.a;
          if (is_mul) begin
            res_d    = prod;
            count_d  = MULT_LOAD;
            commit_d = 1'b1;
            state_d  = RUN;
          end
          if (is_div) begin
            res_d    = {rem, quot};
            count_d  = DIV_LOAD;
            commit_d = (bus.b != 32'd0);
            state_d  = RUN;
          end
          if (is_mac) begin
            res_d    = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
            count_d  = MULT_LOAD;
            commit_d = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (count_q == 32'd1) begin
          if (commit_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
          count_d  = 32'd0;
          commit_d = 1'b0;
          state_d  = IDLE;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.xstall    = bus.busy | (bus.start & is_multi);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;

endmodule
